// File: rtl/team_06_pkg.sv
// Shared types and constants for the team_06 delay-line blocks.
// The audio byte is offset-binary, so silence is 128 rather than 0.
package team_06_pkg;

  localparam logic [7:0] AUDIO_ZERO = 8'd128;

  typedef logic [7:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ
  } state_t;

endpackage

// File: rtl/team_06_delay_ptr.sv
// Circular-buffer bookkeeping: write pointer, fill counter, delay selection
// and the wrap-around read address (write pointer minus the delay).
module team_06_delay_ptr #(
  parameter int ADDR_W = 12,
  parameter int DELAY0 = 1024,
  parameter int DELAY1 = 2048,
  parameter int DELAY2 = 3072,
  parameter int DELAY3 = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        delay_sel,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              full,
  output logic              will_fill
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] delay;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v,
                                                input logic [ADDR_W-1:0] lim);
    return (v >= lim) ? v : v + ADDR_W'(1);
  endfunction

  always_comb begin
    case (delay_sel)
      2'd0:    delay = ADDR_W'(DELAY0);
      2'd1:    delay = ADDR_W'(DELAY1);
      2'd2:    delay = ADDR_W'(DELAY2);
      default: delay = ADDR_W'(DELAY3);
    endcase
  end

  // Plain ADDR_W-bit subtraction gives the modulo-DEPTH wrap for free.
  assign rd_addr   = wr_ptr - delay;
  assign wr_addr   = wr_ptr;
  assign full      = (fill_cnt == delay);
  assign will_fill = full || (fill_cnt == delay - ADDR_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      if (advance)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (clear)
        fill_cnt <= '0;
      else if (advance)
        fill_cnt <= sat_inc(fill_cnt, delay);
    end
  end

endmodule

// File: rtl/team_06_delay_buffer.sv
// Delay-line controller: per sample, reads the byte written DELAY samples ago
// from external SRAM, then writes the new byte into the circular buffer.
module team_06_delay_buffer
  import team_06_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DELAY0 = 1024,
  parameter int DELAY1 = 2048,
  parameter int DELAY2 = 3072,
  parameter int DELAY3 = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [7:0]        save_audio,
  input  logic              save_en,
  input  logic [1:0]        delay_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        past_output,
  output logic              good_data,
  output logic              busy,
  output logic              overrun
);

  state_t            state;
  logic [1:0]        delay_q;
  sample_t           sample_q;
  logic              delay_chg;
  logic              clear;
  logic              advance;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              full;
  logic              will_fill;

  assign delay_chg = (state == IDLE) && (delay_sel != delay_q);
  assign clear     = delay_chg || ((state == IDLE) && sample_valid && !save_en);
  assign advance   = (state == WR_REQ) && mem_req && mem_ack;
  assign busy      = (state != IDLE);

  team_06_delay_ptr #(
    .ADDR_W (ADDR_W),
    .DELAY0 (DELAY0),
    .DELAY1 (DELAY1),
    .DELAY2 (DELAY2),
    .DELAY3 (DELAY3)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .delay_sel (delay_q),
    .clear     (clear),
    .advance   (advance),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .full      (full),
    .will_fill (will_fill)
  );

  always_ff @(posedge clk) begin
    if ((state == IDLE) && sample_valid && save_en)
      sample_q <= save_audio;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      delay_q     <= 2'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      past_output <= AUDIO_ZERO;
      good_data   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (delay_chg) begin
            delay_q     <= delay_sel;
            good_data   <= 1'b0;
            past_output <= AUDIO_ZERO;
          end
          if (sample_valid) begin
            if (save_en) begin
              mem_req <= 1'b1;
              // A delay change in the same cycle invalidates the buffer, so skip the read.
              if (good_data && !delay_chg) begin
                state    <= RD_REQ;
                mem_we   <= 1'b0;
                mem_addr <= rd_addr;
              end else begin
                state     <= WR_REQ;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= save_audio;
              end
            end else begin
              good_data   <= 1'b0;
              past_output <= AUDIO_ZERO;
            end
          end
        end
        RD_REQ: begin
          overrun <= sample_valid;
          if (mem_ack) begin
            past_output <= mem_rdata;
            mem_req     <= 1'b0;
            state       <= WR_REQ;
          end
        end
        WR_REQ: begin
          overrun <= sample_valid;
          // Entered with mem_req low after a read: this is the mandatory bus gap.
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= sample_q;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            good_data <= will_fill;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_delay_buffer.sv
// Directed bench for team_06_delay_buffer with a small byte-SRAM model.
module tb_team_06_delay_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] save_audio = 8'd0;
  logic       save_en = 1'b1;
  logic [1:0] delay_sel = 2'd0;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       mem_ack = 1'b0;
  logic [7:0] past_output;
  logic       good_data;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  team_06_delay_buffer #(
    .ADDR_W (4),
    .DELAY0 (2),
    .DELAY1 (4),
    .DELAY2 (8),
    .DELAY3 (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .save_audio   (save_audio),
    .save_en      (save_en),
    .delay_sel    (delay_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .past_output  (past_output),
    .good_data    (good_data),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // SRAM model: ack after wait_cycles extra cycles, one-cycle ack pulse.
  logic [7:0] sram [16];
  int wait_cycles = 0;
  int wcnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int req_cycles = 0;
  int last_rd = -1;
  int last_wr = -1;

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (mem_req)
      req_cycles <= req_cycles + 1;
    if (mem_req && !mem_ack) begin
      if (wcnt >= wait_cycles) begin
        mem_ack <= 1'b1;
        wcnt    <= 0;
        if (mem_we) begin
          sram[mem_addr] <= mem_wdata;
          wr_cnt         <= wr_cnt + 1;
          last_wr        <= int'(mem_addr);
        end else begin
          mem_rdata <= sram[mem_addr];
          rd_cnt    <= rd_cnt + 1;
          last_rd   <= int'(mem_addr);
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse one sample and wait for the FSM to return to IDLE.
  task automatic send_sample(input logic [1:0] sel, input logic [7:0] data,
                             output int cycles, output int past2);
    @(negedge clk);
    delay_sel = sel;
    @(negedge clk);
    sample_valid = 1'b1;
    save_audio   = data;
    @(negedge clk);
    sample_valid = 1'b0;
    cycles = 0;
    past2  = -1;
    while (busy && cycles < 50) begin
      if (cycles == 2)
        past2 = int'(past_output);
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 50)
      check("busy_timeout", cycles, 0);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    bit         rd;
    int         rd_addr;
    int         wr_addr;
    int         past;
    bit         good;
  } vec_t;

  vec_t tab[10];

  initial begin
    int cyc, p2, rd0, wr0, req0;

    tab[0] = '{2'd0,  8'd10, 1'b0, 0, 0, 128, 1'b0};
    tab[1] = '{2'd0,  8'd20, 1'b0, 0, 1, 128, 1'b1};
    tab[2] = '{2'd0,  8'd30, 1'b1, 0, 2,  10, 1'b1};
    tab[3] = '{2'd0,  8'd40, 1'b1, 1, 3,  20, 1'b1};
    tab[4] = '{2'd1,  8'd50, 1'b0, 0, 4, 128, 1'b0};
    tab[5] = '{2'd1,  8'd60, 1'b0, 0, 5, 128, 1'b0};
    tab[6] = '{2'd1,  8'd70, 1'b0, 0, 6, 128, 1'b0};
    tab[7] = '{2'd1,  8'd80, 1'b0, 0, 7, 128, 1'b1};
    tab[8] = '{2'd1,  8'd90, 1'b1, 4, 8,  50, 1'b1};
    tab[9] = '{2'd1, 8'd100, 1'b1, 5, 9,  60, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_past", int'(past_output), 128);
    check("rst_good", int'(good_data), 0);
    check("rst_req", int'(mem_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // Table: delay 2 stream, then mid-stream change to delay 4
    for (int i = 0; i < 10; i++) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      send_sample(tab[i].sel, tab[i].data, cyc, p2);
      check($sformatf("v%0d_reads", i), rd_cnt - rd0, int'(tab[i].rd));
      check($sformatf("v%0d_writes", i), wr_cnt - wr0, 1);
      check($sformatf("v%0d_wr_addr", i), last_wr, tab[i].wr_addr);
      check($sformatf("v%0d_past", i), int'(past_output), tab[i].past);
      check($sformatf("v%0d_good", i), int'(good_data), int'(tab[i].good));
      if (tab[i].rd) begin
        check($sformatf("v%0d_rd_addr", i), last_rd, tab[i].rd_addr);
        check($sformatf("v%0d_latency_le5", i), int'(cyc <= 5), 1);
        check($sformatf("v%0d_past_at2", i), p2, tab[i].past);
      end
    end

    // Wait-state SRAM with an overrunning sample during the read
    wait_cycles = 3;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    sample_valid = 1'b1;
    save_audio   = 8'd110;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ws_req", int'(mem_req), 1);
    check("ws_we", int'(mem_we), 0);
    check("ws_addr", int'(mem_addr), 6);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check($sformatf("ws_req_hold%0d", k), int'(mem_req), 1);
      check($sformatf("ws_addr_hold%0d", k), int'(mem_addr), 6);
      if (k == 0) check("ws_overrun_pulse", int'(overrun), 1);
      if (k == 1) check("ws_overrun_clear", int'(overrun), 0);
    end
    cyc = 0;
    while (busy && cyc < 50) begin
      if (mem_req && mem_we)
        check("ws_wdata", int'(mem_wdata), 110);
      cyc++;
      @(negedge clk);
    end
    check("ws_done", int'(busy), 0);
    check("ws_reads", rd_cnt - rd0, 1);
    check("ws_writes", wr_cnt - wr0, 1);
    check("ws_wr_addr", last_wr, 10);
    check("ws_past", int'(past_output), 70);
    wait_cycles = 0;
    send_sample(2'd1, 8'd120, cyc, p2);
    check("ws_next_rd_addr", last_rd, 7);
    check("ws_next_wr_addr", last_wr, 11);
    check("ws_next_past", int'(past_output), 80);

    // Asynchronous reset in the middle of a read
    @(negedge clk);
    sample_valid = 1'b1;
    save_audio   = 8'd130;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ar_in_read", int'(mem_req && !mem_we), 1);
    rst = 1'b1;
    #1;
    check("ar_req", int'(mem_req), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_past", int'(past_output), 128);
    check("ar_good", int'(good_data), 0);
    check("ar_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // save_en low: no SRAM traffic at all
    save_en = 1'b0;
    req0 = req_cycles;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      save_audio   = 8'(k + 1);
      @(negedge clk);
      sample_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("se0_req_cycles", req_cycles - req0, 0);
    check("se0_good", int'(good_data), 0);
    check("se0_past", int'(past_output), 128);
    check("se0_busy", int'(busy), 0);
    save_en = 1'b1;

    // Delay 15 from reset: pointer wrap and wrapped read address
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rd0 = rd_cnt;
      send_sample(2'd3, 8'(k), cyc, p2);
      if (k == 15 || k == 16 || k == 17 || k == 19) begin
        check($sformatf("w%0d_wr_addr", k), last_wr, k % 16);
        check($sformatf("w%0d_reads", k), rd_cnt - rd0, 1);
        check($sformatf("w%0d_rd_addr", k), last_rd, (k + 1) % 16);
        check($sformatf("w%0d_past", k), int'(past_output), k - 15);
      end else if (k == 13 || k == 14) begin
        check($sformatf("w%0d_reads", k), rd_cnt - rd0, 0);
        check($sformatf("w%0d_good", k), int'(good_data), int'(k == 14));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
